bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 SHALL have ports req0 and req1, input, 1 bit each: transfer requests from source 0 and source 1.
REQ-004 SHALL have ports dst0 and dst1, input, 1 bit each: requested destination for each source (0 = destination A, 1 = destination B).
REQ-005 SHALL have ports data0 and data1, input, 8 bits each: payload of each source.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: grant to each source, one-hot or zero.
REQ-007 SHALL have port sel, output, 2 bits: bus switch control. sel[0] is the source index; sel[1] is the destination index.
REQ-008 SHALL have port bus_x, output, 8 bits: registered payload driven onto the bus.
REQ-009 SHALL have port bus_vld, output, 1 bit: bus_x and sel are valid this cycle.
REQ-010 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-011 SHALL have port xfer_cnt, output, 8 bits: count of completed transfers.

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: sample requests.
- DRIVE: one cycle; the bus is driven.
- TURN: one cycle; the bus is released.
REQ-013 SHALL sample req0/req1 only in IDLE; requests asserted during DRIVE or TURN SHALL be ignored until the FSM returns to IDLE.
REQ-014 IDLE with no request SHALL stay in IDLE with all outputs holding their idle values.
REQ-015 IDLE with at least one request SHALL, at the edge, select a winner, capture its data/dst, and enter DRIVE.
- Latency: one cycle from the sampling edge to bus_vld=1.
REQ-016 In DRIVE, the FSM SHALL assert:
- bus_vld=1
- gnt of the winner = 1, the other gnt = 0
- sel[0] = winner index
- sel[1] = captured dst
- bus_x = captured data
REQ-017 DRIVE SHALL always go to TURN and TURN SHALL always go to IDLE.
- Max throughput: one transfer per 3 cycles.
REQ-018 In IDLE and TURN, the FSM SHALL hold bus_vld=0, gnt0=gnt1=0, bus_x=8'h00, and sel at its last value.
REQ-019 xfer_cnt SHALL increment by 1 on each DRIVE->TURN edge and SHALL wrap from 255 to 0.
REQ-020 A source holding req high after its grant SHALL be treated as a new request at the next IDLE sample.
REQ-021 A req that drops before an IDLE sample SHALL produce no grant and no transfer.
REQ-022 On simultaneous requests, the winner SHALL be chosen by the tie rule in REQ-026/REQ-027.
REQ-023 A single requester SHALL always win, regardless of the tie rule.

Reset
REQ-024 On assertion of rst_n=0, the block SHALL immediately (asynchronously) apply:
- state = IDLE
- gnt0 = gnt1 = 0
- bus_vld = 0
- sel = 2'b00
- bus_x = 8'h00
- busy = 0
- xfer_cnt = 8'h00
- last-granted pointer = 1
REQ-025 Reset asserted mid-DRIVE SHALL abort the transfer without incrementing xfer_cnt; the first request after reset release SHALL be sampled at the first rising edge with rst_n=1.

Configuration
REQ-026 With macro BUS_ARB_RR_EN defined, ties SHALL be resolved round-robin: the source not granted last wins, and the pointer updates on each DRIVE entry.
REQ-027 Without BUS_ARB_RR_EN, ties SHALL be resolved by fixed priority with source 0 always winning, and the pointer logic SHALL be absent.

Verification
REQ-028 req0=1, dst0=1, data0=8'hA5 in IDLE -> next cycle: gnt0=1, sel=2'b10, bus_x=8'hA5, bus_vld=1; then TURN with bus_vld=0; xfer_cnt=1.
REQ-029 req0=req1=1 held continuously:
- with BUS_ARB_RR_EN: grants alternate 0,1,0,1, each DRIVE 3 cycles apart.
- without BUS_ARB_RR_EN: grant 0 every time.
REQ-030 req1 pulsed only during DRIVE of a source-0 transfer -> no gnt1 ever; xfer_cnt increments once.
REQ-031 256 back-to-back single-source transfers -> xfer_cnt reads 8'h00 after the 256th, 8'h01 after the 257th.
REQ-032 rst_n driven low mid-DRIVE (data 8'h3C) -> same-cycle bus_vld=0, gnt=0, bus_x=8'h00, xfer_cnt unchanged at 0; after release with req1=1, dst1=0, data1=8'h77 -> gnt1=1, sel=2'b01, bus_x=8'h77.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-source, two-destination bus arbiter: IDLE -> DRIVE -> TURN, one transfer per three cycles.
// Optional macro BUS_ARB_RR_EN selects round-robin tie-breaking; otherwise source 0 wins ties.
module bus_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       dst0,
   input  logic       dst1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [1:0] sel,
   output logic [7:0] bus_x,
   output logic       bus_vld,
   output logic       busy,
   output logic [7:0] xfer_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic [1:0] sel_q, sel_d;
   logic [7:0] bus_x_q, bus_x_d;
   logic       bus_vld_q, bus_vld_d;
   logic       busy_q, busy_d;
   logic [7:0] xfer_cnt_q, xfer_cnt_d;
   logic       any_req_s;
   logic       win_s;

   assign any_req_s = req0 | req1;

`ifdef BUS_ARB_RR_EN
   logic last_q, last_d;

   // Winner select: on a tie the source not granted last wins
   always_comb begin
      if (req0 && req1) begin
         win_s = ~last_q;
      end else if (req1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Pointer advances only when a transfer is launched
   always_comb begin
      if ((state_q == IDLE) && any_req_s) begin
         last_d = win_s;
      end else begin
         last_d = last_q;
      end
   end

   // Last-granted pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Winner select: fixed priority, source 0 wins any tie
   always_comb begin
      if (req1 && !req0) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end
`endif

   // Next-state and next-output logic; every output is registered
   always_comb begin
      state_d    = state_q;
      gnt0_d     = gnt0_q;
      gnt1_d     = gnt1_q;
      sel_d      = sel_q;
      bus_x_d    = bus_x_q;
      bus_vld_d  = bus_vld_q;
      xfer_cnt_d = xfer_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               state_d   = DRIVE;
               gnt0_d    = ~win_s;
               gnt1_d    = win_s;
               sel_d     = {(win_s ? dst1 : dst0), win_s};
               bus_x_d   = win_s ? data1 : data0;
               bus_vld_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         DRIVE: begin
            state_d    = TURN;
            gnt0_d     = 1'b0;
            gnt1_d     = 1'b0;
            bus_x_d    = 8'h00;
            bus_vld_d  = 1'b0;
            xfer_cnt_d = xfer_cnt_q + 8'd1;
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            gnt0_d    = 1'b0;
            gnt1_d    = 1'b0;
            bus_x_d   = 8'h00;
            bus_vld_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         sel_q      <= 2'b00;
         bus_x_q    <= 8'h00;
         bus_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         xfer_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         sel_q      <= sel_d;
         bus_x_q    <= bus_x_d;
         bus_vld_q  <= bus_vld_d;
         busy_q     <= busy_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign sel      = sel_q;
   assign bus_x    = bus_x_q;
   assign bus_vld  = bus_vld_q;
   assign busy     = busy_q;
   assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs driven and outputs sampled on the falling clock edge.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, dst0 = 1'b0, dst1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       gnt0, gnt1, bus_vld, busy;
   logic [1:0] sel;
   logic [7:0] bus_x, xfer_cnt;

   int         vectors = 0;
   int         errors  = 0;
   logic       last_m;
   logic [7:0] cnt_m;
   logic       w;

   bus_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .dst0(dst0), .dst1(dst1),
      .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .bus_x(bus_x),
      .bus_vld(bus_vld), .busy(busy), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   // Expected winner from the request pair and the model's last-granted pointer
   function automatic logic pick(input logic r0, input logic r1);
      if (r0 && r1) begin
`ifdef BUS_ARB_RR_EN
         return ~last_m;
`else
         return 1'b0;
`endif
      end
      return r1;
   endfunction

   task automatic chk(input string tag, input logic g0, input logic g1, input logic [1:0] s,
                      input logic [7:0] bx, input logic v, input logic b, input logic [7:0] c);
      logic [21:0] obs, exp;
      obs = {gnt0, gnt1, sel, bus_x, bus_vld, busy, xfer_cnt};
      exp = {g0, g1, s, bx, v, b, c};
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h ({gnt0,gnt1,sel,bus_x,vld,busy,cnt})", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      last_m = 1'b1;
      cnt_m  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);

      // Single request from source 0 to destination B
      rst_n = 1'b1;
      req0 = 1'b1; dst0 = 1'b1; data0 = 8'hA5;
      w = pick(1'b1, 1'b0); last_m = w;
      @(negedge clk);
      chk("single_drive", 1'b1, 1'b0, 2'b10, 8'hA5, 1'b1, 1'b1, 8'h00);
      req0 = 1'b0;
      @(negedge clk);
      chk("single_turn", 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 8'h01);
      @(negedge clk);
      chk("single_idle", 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 8'h01);
      @(negedge clk);
      chk("idle_hold", 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 8'h01);
      cnt_m = 8'h01;

      // Both sources requesting continuously
      req0 = 1'b1; req1 = 1'b1; dst0 = 1'b0; dst1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      for (int k = 0; k < 4; k++) begin
         w = pick(1'b1, 1'b1); last_m = w;
         @(negedge clk);
         chk("tie_drive", ~w, w, {w, w}, (w ? 8'h22 : 8'h11), 1'b1, 1'b1, cnt_m);
         cnt_m = cnt_m + 8'd1;
         @(negedge clk);
         chk("tie_turn", 1'b0, 1'b0, {w, w}, 8'h00, 1'b0, 1'b1, cnt_m);
         @(negedge clk);
         chk("tie_idle", 1'b0, 1'b0, {w, w}, 8'h00, 1'b0, 1'b0, cnt_m);
      end

      // req1 pulsed only while source 0 is driving must be ignored
      req1 = 1'b0; req0 = 1'b1; dst0 = 1'b0; data0 = 8'h5A;
      w = pick(1'b1, 1'b0); last_m = w;
      @(negedge clk);
      chk("pulse_drive", 1'b1, 1'b0, 2'b00, 8'h5A, 1'b1, 1'b1, cnt_m);
      req0 = 1'b0; req1 = 1'b1;
      cnt_m = cnt_m + 8'd1;
      @(negedge clk);
      chk("pulse_turn", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, cnt_m);
      req1 = 1'b0;
      @(negedge clk);
      chk("pulse_idle", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, cnt_m);
      @(negedge clk);
      chk("pulse_no_gnt1", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, cnt_m);

      // Asynchronous reset in the middle of a DRIVE cycle
      rst_n = 1'b0;
      #1;
      chk("reset_again", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
      last_m = 1'b1; cnt_m = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b1; dst0 = 1'b1; data0 = 8'h3C;
      @(negedge clk);
      chk("abort_drive", 1'b1, 1'b0, 2'b10, 8'h3C, 1'b1, 1'b1, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_reset", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
      req0 = 1'b0; req1 = 1'b1; dst1 = 1'b0; data1 = 8'h77;
      @(negedge clk);
      chk("abort_held", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      w = pick(1'b0, 1'b1); last_m = w;
      @(negedge clk);
      chk("post_reset_drive", 1'b0, 1'b1, 2'b01, 8'h77, 1'b1, 1'b1, 8'h00);
      req1 = 1'b0;
      @(negedge clk);
      chk("post_reset_turn", 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 8'h01);

      // 257 back-to-back transfers from a fresh reset: counter wraps
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("wrap_reset", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
      last_m = 1'b1; cnt_m = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b1; dst0 = 1'b0; data0 = 8'hC3;
      for (int i = 1; i <= 257; i++) begin
         @(negedge clk);
         chk("wrap_drive", 1'b1, 1'b0, 2'b00, 8'hC3, 1'b1, 1'b1, cnt_m);
         cnt_m = cnt_m + 8'd1;
         @(negedge clk);
         if (i >= 255 || i == 1) begin
            chk("wrap_turn", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, cnt_m);
         end
         if (i == 256) begin
            chk("wrap_256", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h00);
         end
         if (i == 257) begin
            chk("wrap_257", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h01);
         end
         @(negedge clk);
         if (i == 257) begin
            req0 = 1'b0;
         end
      end
      @(negedge clk);
      chk("final_idle", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
